adc_scan_sequencer: RTL and testbench
=====================================

# adc_scan_sequencer

Round-robin scheduler that shares the board's serial ADC link between four analog channels (X1..X4). It issues one command byte per channel over a byte-level UART transmitter and collects the two-byte reply from the matching receiver. It publishes each conversion as a one-cycle sample strobe and holds the latest value per channel. It sits between the 250 kbaud serial core and display/consumer logic such as the LED display driver.

## Interface

Parameters:
- CHANNELS, 4: number of scanned channels, 1..4.
- CMD_BASE, 8'hA1: command byte for channel 0; channel n sends CMD_BASE+n.
- TIMEOUT_CYCLES, 12000: clk12MHz cycles allowed per reply byte (1 ms).

Ports:
- clk12MHz  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  high = keep scanning; low = finish current transaction, then idle.
- chan_mask  in  4  bit n set = channel n included in the scan; bits >= CHANNELS are ignored.
- tx_data  out  8  command byte.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts when tx_valid && tx_ready.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe per received byte.
- busy  out  1  high in any state except IDLE.
- sample_valid  out  1  one-cycle strobe, new sample published.
- sample_chan  out  2  channel of the current/last sample.
- sample_value  out  16  value of the current/last sample.
- results  out  64  latest value per channel, channel n at [16n+15:16n].
- timeout_count  out  8  saturating count of timed-out transactions.

## Operation

States: IDLE, SEND, WAIT_HI, WAIT_LO, PUBLISH.
- IDLE: if enable and the effective mask is nonzero, choose the next channel and go to SEND.
  - Search starts at last_chan+1, wraps modulo CHANNELS, and takes the first set mask bit. last_chan resets to CHANNELS-1, so channel 0 is tried first.
  - Mask zero: stay in IDLE.
- SEND: tx_valid=1, tx_data=CMD_BASE+chan. On handshake go to WAIT_HI, clear the timer.
- WAIT_HI: on rx_valid, latch hi byte, clear the timer, go to WAIT_LO.
- WAIT_LO: on rx_valid, form value = {hi, rx_data}, go to PUBLISH.
- PUBLISH: pulse sample_valid, update results[chan], update last_chan, go to IDLE.
- Timeout: in WAIT_HI or WAIT_LO, if the timer reaches TIMEOUT_CYCLES-1 without rx_valid:
  - increment timeout_count, saturating at 255;
  - set last_chan=chan, leave results unchanged, no sample_valid;
  - go to IDLE.
- rx_valid in IDLE, SEND or PUBLISH is discarded.
- enable falling mid-transaction has no effect until the transaction ends in IDLE.
- chan_mask is sampled only in IDLE.

## Timing

- Reset values:
  - outputs: tx_valid=0, tx_data=0, busy=0, sample_valid=0, sample_chan=0, sample_value=0, results=0, timeout_count=0;
  - internal: state=IDLE, last_chan=CHANNELS-1.
- Reset wins over every other event in the same cycle. Reset mid-transaction abandons it; any reply bytes that arrive later are discarded in IDLE.
- IDLE->SEND takes 1 cycle; tx_valid is high the cycle after the decision.
- tx_data must remain stable while tx_valid=1 and tx_ready=0.
- Last rx byte -> sample_valid takes 1 cycle. results and sample_* update on the same edge that asserts sample_valid.
- Minimum transaction is 5 cycles plus UART time. A back-to-back scan re-enters SEND 2 cycles after PUBLISH.
- rx_valid in the same cycle as timer expiry: the byte is accepted and no timeout occurs.
- Timer width is ceil(log2(TIMEOUT_CYCLES)) bits.

## Configuration

- ADC_SEQ_FILTER_EN defined: each channel holds a 2-tap average.
  - stored = (old + new) >> 1, using a 17-bit sum.
  - The first sample after reset for each channel loads directly (one valid flag per channel).
  - sample_value carries the filtered value.
- Not defined: results and sample_value carry the raw {hi, lo} value. No valid flags are implemented.

## Test plan

- Reset, enable=1, mask=4'b1111, replies 0x01,0x23 every time -> tx_data sequence A1,A2,A3,A4,A1; each sample_valid has sample_value=16'h0123; results=64'h0123_0123_0123_0123.
- mask=4'b0101 -> commands alternate A1,A3,A1; sample_chan alternates 0,2; results[31:16] stays 0.
- No reply after A2 -> after 12000 cycles in WAIT_HI, timeout_count=1, no sample_valid, next command A3.
- tx_ready held low 50 cycles in SEND -> tx_valid and tx_data=A1 stable for 50 cycles; one command sent.
- enable dropped in WAIT_LO -> transaction completes with sample_valid, then busy=0 and no further tx_valid. Reset asserted in WAIT_HI -> next cycle all outputs at reset values.
- With ADC_SEQ_FILTER_EN: channel 0 replies 0x0100 then 0x0300 -> results[15:0] = 0x0100, then 0x0200.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// Round-robin scan of up to four ADC channels over a byte UART link; publishes one sample per reply.
// Optional per-channel 2-tap averaging when ADC_SEQ_FILTER_EN is defined.
module adc_scan_sequencer #(
  parameter int         CHANNELS       = 4,
  parameter logic [7:0] CMD_BASE       = 8'hA1,
  parameter int         TIMEOUT_CYCLES = 12000
) (
  input  logic        clk12MHz,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  chan_mask,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        busy,
  output logic        sample_valid,
  output logic [1:0]  sample_chan,
  output logic [15:0] sample_value,
  output logic [63:0] results,
  output logic [7:0]  timeout_count
);

  localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    CH_MASK  = 4'((1 << CHANNELS) - 1);
  localparam logic [1:0]    LAST_RST = 2'(CHANNELS - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, PUBLISH} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    chan_reg, chan_next;
  logic [1:0]    last_chan_reg, last_chan_next;
  logic [7:0]    hi_reg, hi_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [7:0]    timeout_reg, timeout_next;
  logic [1:0]    sample_chan_reg;
  logic [15:0]   sample_value_reg;

  logic [3:0]    eff_mask;
  logic          pick_found;
  logic [1:0]    pick_chan;
  logic [1:0]    cand;
  logic          publish_load;
  logic [15:0]   raw_value;
  logic [15:0]   new_value;
  logic [15:0]   res_all [4];

  assign eff_mask  = chan_mask & CH_MASK;
  assign raw_value = {hi_reg, rx_data};

  // Descending scan so the smallest offset from last_chan+1 wins.
  always_comb begin
    pick_found = 1'b0;
    pick_chan  = '0;
    cand       = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      cand = 2'((int'(last_chan_reg) + i) % CHANNELS);
      if (eff_mask[cand]) begin
        pick_found = 1'b1;
        pick_chan  = cand;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    chan_next      = chan_reg;
    last_chan_next = last_chan_reg;
    hi_next        = hi_reg;
    timer_next     = timer_reg;
    timeout_next   = timeout_reg;
    publish_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable && pick_found) begin
          chan_next  = pick_chan;
          state_next = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          timer_next = '0;
          state_next = WAIT_HI;
        end
      end
      WAIT_HI, WAIT_LO: begin
        if (rx_valid) begin
          timer_next = '0;
          if (state_reg == WAIT_HI) begin
            hi_next    = rx_data;
            state_next = WAIT_LO;
          end else begin
            publish_load = 1'b1;
            state_next   = PUBLISH;
          end
        end else if (timer_reg == T_LAST) begin
          if (timeout_reg != 8'hFF) timeout_next = timeout_reg + 8'd1;
          last_chan_next = chan_reg;
          state_next     = IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      PUBLISH: begin
        last_chan_next = chan_reg;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ADC_SEQ_FILTER_EN
  logic [3:0]  vld_all;
  logic [16:0] sum;
  assign sum       = {1'b0, res_all[chan_reg]} + {1'b0, raw_value};
  assign new_value = vld_all[chan_reg] ? sum[16:1] : raw_value;
`else
  assign new_value = raw_value;
`endif

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      if (gi < CHANNELS) begin : g_used
        logic [15:0] value_reg;
        always_ff @(posedge clk12MHz) begin
          if (reset) begin
            value_reg <= '0;
          end else if (publish_load && chan_reg == 2'(gi)) begin
            value_reg <= new_value;
          end
        end
        assign res_all[gi] = value_reg;
`ifdef ADC_SEQ_FILTER_EN
        // First sample after reset loads directly instead of averaging with zero.
        logic valid_reg;
        always_ff @(posedge clk12MHz) begin
          if (reset) begin
            valid_reg <= 1'b0;
          end else if (publish_load && chan_reg == 2'(gi)) begin
            valid_reg <= 1'b1;
          end
        end
        assign vld_all[gi] = valid_reg;
`endif
      end else begin : g_unused
        assign res_all[gi] = '0;
`ifdef ADC_SEQ_FILTER_EN
        assign vld_all[gi] = 1'b0;
`endif
      end
      assign results[16*gi +: 16] = res_all[gi];
    end
  endgenerate

  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      state_reg        <= IDLE;
      chan_reg         <= '0;
      last_chan_reg    <= LAST_RST;
      hi_reg           <= '0;
      timer_reg        <= '0;
      timeout_reg      <= '0;
      sample_chan_reg  <= '0;
      sample_value_reg <= '0;
    end else begin
      state_reg     <= state_next;
      chan_reg      <= chan_next;
      last_chan_reg <= last_chan_next;
      hi_reg        <= hi_next;
      timer_reg     <= timer_next;
      timeout_reg   <= timeout_next;
      if (publish_load) begin
        sample_chan_reg  <= chan_reg;
        sample_value_reg <= new_value;
      end
    end
  end

  assign tx_valid      = (state_reg == SEND);
  assign tx_data       = tx_valid ? (CMD_BASE + {6'b0, chan_reg}) : 8'h00;
  assign busy          = (state_reg != IDLE);
  assign sample_valid  = (state_reg == PUBLISH);
  assign sample_chan   = sample_chan_reg;
  assign sample_value  = sample_value_reg;
  assign timeout_count = timeout_reg;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Scoreboard bench for adc_scan_sequencer: stimulus queues expected commands/samples, a negedge monitor checks them.
module tb_adc_scan_sequencer;

  logic        clk12MHz = 1'b0;
  logic        reset, enable, tx_ready, rx_valid;
  logic [3:0]  chan_mask;
  logic [7:0]  rx_data, tx_data, timeout_count;
  logic        tx_valid, busy, sample_valid;
  logic [1:0]  sample_chan;
  logic [15:0] sample_value;
  logic [63:0] results;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  cmd_q[$];
  logic [17:0] samp_q[$];

  always #41 clk12MHz = ~clk12MHz;

  adc_scan_sequencer dut (
    .clk12MHz(clk12MHz), .reset(reset), .enable(enable), .chan_mask(chan_mask),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sample_valid(sample_valid), .sample_chan(sample_chan), .sample_value(sample_value),
    .results(results), .timeout_count(timeout_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every command handshake and every sample strobe must match the queue head.
  always @(negedge clk12MHz) begin
    if (!reset) begin
      if (tx_valid && tx_ready) begin
        if (cmd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_cmd: got %0h expected none", tx_data);
        end else begin
          logic [7:0] e;
          e = cmd_q.pop_front();
          $display("txn cmd=%h", tx_data);
          chk("tx_data", 64'(tx_data), 64'(e));
        end
      end
      if (sample_valid) begin
        if (samp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_sample: got chan %0d value %0h expected none", sample_chan, sample_value);
        end else begin
          logic [17:0] s;
          s = samp_q.pop_front();
          $display("txn sample chan=%0d value=%h", sample_chan, sample_value);
          chk("sample_chan", 64'(sample_chan), 64'(s[17:16]));
          chk("sample_value", 64'(sample_value), 64'(s[15:0]));
          chk("results_slice", (results >> (16 * sample_chan)) & 64'hFFFF, 64'(s[15:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk12MHz);
    #1;
  endtask

  task automatic expect_txn(input logic [7:0] cmd, input logic [1:0] ch, input logic [15:0] val);
    cmd_q.push_back(cmd);
    samp_q.push_back({ch, val});
  endtask

  task automatic wait_hs();
    int n = 0;
    while (!(tx_valid && tx_ready) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL wait_cmd: got no handshake within 200 cycles expected one");
    end else begin
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // last=1 drops enable while the DUT is in WAIT_LO.
  task automatic complete(input logic [7:0] hi, input logic [7:0] lo, input bit last);
    wait_hs();
    tick();
    send_byte(hi);
    if (last) enable = 1'b0;
    send_byte(lo);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
    chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_sample_valid"}, 64'(sample_valid), 64'd0);
    chk({tag, "_sample_chan"}, 64'(sample_chan), 64'd0);
    chk({tag, "_sample_value"}, 64'(sample_value), 64'd0);
    chk({tag, "_results"}, results, 64'd0);
    chk({tag, "_timeout_count"}, 64'(timeout_count), 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    repeat (3) tick();
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
  endtask

  task automatic do_reset();
    chk("queues_drained", 64'(cmd_q.size() + samp_q.size()), 64'd0);
    reset = 1'b1; enable = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    #(60000 * 82);
    $display("FAIL watchdog: got no finish expected finish within 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stable;
    reset = 1'b1; enable = 1'b0; chan_mask = 4'h0; tx_ready = 1'b1;
    rx_valid = 1'b0; rx_data = 8'h00;

    // Reset values
    do_reset();
    chk_reset_outputs("rst");
    chk("mask0_idle", 64'(busy), 64'd0);

    // Full mask: A1..A4 then wrap to A1
    chan_mask = 4'b1111;
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_txn(8'hA1 + 8'(k % 4), 2'(k % 4), 16'h0123);
      complete(8'h01, 8'h23, k == 4);
    end
    chk_idle("full");
    chk("full_results", results, 64'h0123_0123_0123_0123);

    // Sparse mask 0101: A1, A3, A1
    do_reset();
    chan_mask = 4'b0101;
    enable = 1'b1;
    expect_txn(8'hA1, 2'd0, 16'h0A0B); complete(8'h0A, 8'h0B, 0);
    expect_txn(8'hA3, 2'd2, 16'h0C0D); complete(8'h0C, 8'h0D, 0);
    expect_txn(8'hA1, 2'd0, 16'h0A0B); complete(8'h0A, 8'h0B, 1);
    chk_idle("sparse");
    chk("sparse_results", results, 64'h0000_0C0D_0000_0A0B);

    // Timeout on A2, then reply exactly on the expiry cycle for A3
    do_reset();
    chan_mask = 4'b1111;
    enable = 1'b1;
    expect_txn(8'hA1, 2'd0, 16'h1111); complete(8'h11, 8'h11, 0);
    cmd_q.push_back(8'hA2);
    wait_hs();
    repeat (11999) tick();
    chk("timeout_before", 64'(timeout_count), 64'd0);
    chk("busy_before_timeout", 64'(busy), 64'd1);
    tick();
    chk("timeout_after", 64'(timeout_count), 64'd1);
    chk("idle_after_timeout", 64'(busy), 64'd0);
    expect_txn(8'hA3, 2'd2, 16'h2233);
    wait_hs();
    repeat (11999) tick();
    send_byte(8'h22);
    enable = 1'b0;
    send_byte(8'h33);
    chk_idle("timeout");
    chk("timeout_edge_no_inc", 64'(timeout_count), 64'd1);
    chk("timeout_results", results, 64'h0000_2233_0000_1111);

    // tx_ready held low for 50 cycles
    do_reset();
    chan_mask = 4'b0001;
    tx_ready = 1'b0;
    enable = 1'b1;
    expect_txn(8'hA1, 2'd0, 16'h4455);
    tick();
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (!(tx_valid === 1'b1 && tx_data === 8'hA1)) stable = 1'b0;
      tick();
    end
    chk("tx_hold_stable", 64'(stable), 64'd1);
    tx_ready = 1'b1;
    complete(8'h44, 8'h55, 1);
    chk_idle("hold");
    chk("hold_results", results, 64'h0000_0000_0000_4455);

    // Reset in WAIT_HI; late reply bytes must be discarded
    enable = 1'b1;
    cmd_q.push_back(8'hA1);
    wait_hs();
    tick();
    chk("in_wait_hi_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    reset = 1'b0;
    enable = 1'b0;
    send_byte(8'h12);
    send_byte(8'h34);
    chk_idle("midrst");
    chk("midrst_results", results, 64'd0);

`ifdef ADC_SEQ_FILTER_EN
    // 2-tap average: first sample loads, second averages
    do_reset();
    chan_mask = 4'b0001;
    enable = 1'b1;
    expect_txn(8'hA1, 2'd0, 16'h0100); complete(8'h01, 8'h00, 0);
    chk("filter_first", 64'(results[15:0]), 64'h0100);
    expect_txn(8'hA1, 2'd0, 16'h0200); complete(8'h03, 8'h00, 1);
    chk("filter_avg", 64'(results[15:0]), 64'h0200);
    chk_idle("filter");
`endif

    tick();
    chk("queues_empty_end", 64'(cmd_q.size() + samp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
